// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode 7-segment controller: per-digit register file, refresh prescaler,
// per-digit blink, 8-level PWM brightness and a one-cycle ghost blank at every slot start.
module seg7_scan_ctrl #(
    parameter  int NUM_DIGITS = 4,
    parameter  int DIV_WIDTH  = 16,
    parameter  int BLINK_BIT  = 5,
    localparam int AW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  disp_en,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic                  wr_raw,
    input  logic [6:0]            wr_data,
    input  logic                  wr_dp,
    input  logic [NUM_DIGITS-1:0] blink_mask,
    input  logic [2:0]            brightness,
    output logic [6:0]            displayCA,
    output logic                  displayDP,
    output logic [NUM_DIGITS-1:0] displayAN,
    output logic [AW-1:0]         scan_idx,
    output logic                  frame_done
);

    // Each entry is {raw, payload[6:0], dp}.
    logic [8:0]            digit_q [NUM_DIGITS];
    logic [DIV_WIDTH-1:0]  prescaler;
    logic [BLINK_BIT:0]    frame_cnt;

    logic                  tick;
    logic                  last_digit;
    logic [8:0]            sel;
    logic [6:0]            seg_next;
    logic                  lit;
    logic [NUM_DIGITS-1:0] an_next;

    function automatic logic [6:0] hex_decode(input logic [3:0] code);
        logic [6:0] seg;
        case (code)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

    assign tick       = &prescaler;
    assign last_digit = (scan_idx == AW'(NUM_DIGITS - 1));
    assign sel        = digit_q[scan_idx];

    // Anode is lit only inside the PWM window, never on the first count of a slot, and not during blink-off.
    always_comb begin
        seg_next = sel[8] ? sel[7:1] : hex_decode(sel[4:1]);
        lit      = disp_en
                && (prescaler != '0)
                && (prescaler[DIV_WIDTH-1 -: 3] <= brightness)
                && !(blink_mask[scan_idx] && frame_cnt[BLINK_BIT]);
        an_next  = lit ? ~(NUM_DIGITS'(1) << scan_idx) : '1;
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            prescaler  <= '0;
            frame_cnt  <= '0;
            scan_idx   <= '0;
            frame_done <= 1'b0;
        end else begin
            prescaler  <= prescaler + 1'b1;
            frame_done <= tick && last_digit;
            if (tick) begin
                if (last_digit) begin
                    scan_idx  <= '0;
                    frame_cnt <= frame_cnt + 1'b1;
                end else begin
                    scan_idx  <= scan_idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_q[i] <= {1'b1, 7'h7F, 1'b0};
            end
        end else if (wr_en && (int'(wr_addr) < NUM_DIGITS)) begin
            digit_q[wr_addr] <= {wr_raw, wr_data, wr_dp};
        end
    end

    // Pins are a registered image of the current scan state, so they trail it by one cycle.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            displayCA <= 7'h7F;
            displayDP <= 1'b1;
            displayAN <= '1;
        end else begin
            displayCA <= seg_next;
            displayDP <= ~sel[0];
            displayAN <= an_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (4 digits, 16-cycle slots, blink phase every 2 frames).
module tb_seg7_scan_ctrl;

    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic       disp_en = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = '0;
    logic       wr_raw = 1'b0;
    logic [6:0] wr_data = '0;
    logic       wr_dp = 1'b0;
    logic [3:0] blink_mask = '0;
    logic [2:0] brightness = '0;
    logic [6:0] displayCA;
    logic       displayDP;
    logic [3:0] displayAN;
    logic [1:0] scan_idx;
    logic       frame_done;

    int compared = 0;
    int mismatched = 0;

    // Reference state: edges since reset plus the digit contents.
    int         cnt = 0;
    logic       mRaw  [4];
    logic [6:0] mData [4];
    logic       mDp   [4];
    logic [6:0] hexTab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    seg7_scan_ctrl #(.NUM_DIGITS(4), .DIV_WIDTH(4), .BLINK_BIT(1)) dut (
        .CLK(CLK), .Reset(Reset), .disp_en(disp_en), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_raw(wr_raw), .wr_data(wr_data), .wr_dp(wr_dp), .blink_mask(blink_mask),
        .brightness(brightness), .displayCA(displayCA), .displayDP(displayDP),
        .displayAN(displayAN), .scan_idx(scan_idx), .frame_done(frame_done)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s at t=%0t cnt=%0d: observed %b expected %b", tag, $time, cnt, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [2:0] br, input logic [3:0] bm);
        disp_en    = en;
        brightness = br;
        blink_mask = bm;
    endtask

    task automatic writeDigit(input logic [1:0] a, input logic raw, input logic [6:0] d, input logic dp);
        wr_en = 1'b1; wr_addr = a; wr_raw = raw; wr_data = d; wr_dp = dp;
    endtask

    // One clock: predict from pre-edge state and inputs, compare after the edge, then advance the model.
    task automatic stepCycle();
        logic [3:0] eAn;
        logic [6:0] eCa;
        logic       eDp, eFd, lit;
        logic [1:0] eIdx;
        int p, s, ph;
        if (Reset) begin
            eAn = 4'hF; eCa = 7'h7F; eDp = 1'b1; eIdx = 2'd0; eFd = 1'b0;
        end else begin
            p   = cnt % 16;
            s   = (cnt / 16) % 4;
            ph  = (cnt / 128) % 2;
            lit = disp_en && (p != 0) && ((p / 2) <= int'(brightness)) && !(blink_mask[s] && ph == 1);
            eAn = lit ? 4'(15 - (1 << s)) : 4'hF;
            eCa = mRaw[s] ? mData[s] : hexTab[mData[s][3:0]];
            eDp = ~mDp[s];
            eIdx = 2'(((cnt + 1) / 16) % 4);
            eFd = ((cnt % 64) == 63);
        end
        @(posedge CLK);
        #1;
        checkOutput("AN", 7'(displayAN), 7'(eAn));
        checkOutput("CA", displayCA, eCa);
        checkOutput("DP", 7'(displayDP), 7'(eDp));
        checkOutput("IDX", 7'(scan_idx), 7'(eIdx));
        checkOutput("FD", 7'(frame_done), 7'(eFd));
        if (Reset) begin
            cnt = 0;
            for (int i = 0; i < 4; i++) begin
                mRaw[i] = 1'b1; mData[i] = 7'h7F; mDp[i] = 1'b0;
            end
        end else begin
            if (wr_en) begin
                mRaw[wr_addr] = wr_raw; mData[wr_addr] = wr_data; mDp[wr_addr] = wr_dp;
            end
            cnt++;
        end
        wr_en = 1'b0;
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) stepCycle();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            mRaw[i] = 1'b1; mData[i] = 7'h7F; mDp[i] = 1'b0;
        end
        #1;
        Reset = 1'b1;
        runCycles(3);
        Reset = 1'b0;
        $display("[TB] idle scan with blank digits");
        applyStimulus(1'b0, 3'd7, 4'b0000);
        runCycles(100);

        $display("[TB] hex 0,1,E,F at full brightness");
        applyStimulus(1'b1, 3'd7, 4'b0000);
        writeDigit(2'd0, 1'b0, 7'h00, 1'b0); stepCycle();
        writeDigit(2'd1, 1'b0, 7'h01, 1'b0); stepCycle();
        writeDigit(2'd2, 1'b0, 7'h0E, 1'b0); stepCycle();
        writeDigit(2'd3, 1'b0, 7'h0F, 1'b0); stepCycle();
        runCycles(80);

        $display("[TB] brightness levels");
        applyStimulus(1'b1, 3'd0, 4'b0000);
        runCycles(64);
        applyStimulus(1'b1, 3'd3, 4'b0000);
        runCycles(64);

        $display("[TB] blink on digit 2");
        applyStimulus(1'b1, 3'd7, 4'b0100);
        runCycles(300);

        $display("[TB] raw segments with decimal point");
        applyStimulus(1'b1, 3'd7, 4'b0000);
        writeDigit(2'd1, 1'b1, 7'h2A, 1'b1); stepCycle();
        runCycles(70);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 2000; i++) begin
            Reset   = ($urandom_range(0, 299) == 0);
            disp_en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) brightness = 3'($urandom);
            if ($urandom_range(0, 99) == 0) blink_mask = 4'($urandom);
            if ($urandom_range(0, 3) == 0)
                writeDigit(2'($urandom), 1'($urandom), 7'($urandom), 1'($urandom));
            stepCycle();
        end
        Reset = 1'b0;

        $display("[TB] reset in the middle of digit 2's slot");
        applyStimulus(1'b1, 3'd7, 4'b0000);
        writeDigit(2'd2, 1'b0, 7'h08, 1'b1); stepCycle();
        for (int i = 0; i < 100 && !(((cnt / 16) % 4) == 2 && (cnt % 16) == 5); i++) stepCycle();
        Reset = 1'b1;
        stepCycle();
        Reset = 1'b0;
        runCycles(70);

        $display("[TB] display disabled while scanning");
        writeDigit(2'd0, 1'b0, 7'h05, 1'b1); stepCycle();
        applyStimulus(1'b0, 3'd7, 4'b0000);
        runCycles(80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
